// File: rtl/alu_div_ctrl_pkg.sv
// rtl/alu_div_ctrl_pkg.sv - shared constants for the divider controller and its ALU
//
// Divide op encodings, ALU op codes and small op-decode helpers shared by
// alu_div_ctrl and alu_div_ctrl_alu.
package alu_div_ctrl_pkg;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4
    } alu_op_e;

    // DIV and REM are the signed ops; bit 0 of the encoding marks unsigned.
    function automatic logic op_is_signed(div_op_e op);
        return ~op[0];
    endfunction

    // REM and REMU return the remainder; bit 1 of the encoding selects it.
    function automatic logic op_is_rem(div_op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/alu_div_ctrl_alu.sv
// rtl/alu_div_ctrl_alu.sv - small combinational ALU used for the trial subtraction
//
// Ports:
//   op     : ALU operation (alu_op_e)
//   a, b   : W-bit operands
//   result : W-bit result, modulo 2^W
module alu_div_ctrl_alu
    import alu_div_ctrl_pkg::*;
#(
    parameter int W = 33
) (
    input  alu_op_e        op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [W-1:0]   result
);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_div_ctrl.sv
// rtl/alu_div_ctrl.sv - iterative restoring divider controller (DIV/DIVU/REM/REMU)
//
// Ports:
//   clock  : single clock, rising edge
//   reset  : synchronous active-low reset
//   start  : operation request, sampled only in IDLE or DONE
//   op     : DIV, DIVU, REM, REMU
//   inA    : dividend
//   inB    : divisor
//   flush  : synchronous abort, returns to IDLE without a done pulse
//   busy   : high in ITER and FIX
//   done   : one-cycle pulse, out valid
//   out    : quotient or remainder, held until replaced by a new result
module alu_div_ctrl
    import alu_div_ctrl_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] inA,
    input  logic [N-1:0] inB,
    input  logic         flush,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] out
);

    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e state, state_nxt;

    div_op_e        op_q;
    logic [N-1:0]   dvd_q;      // dividend, shifted left; fills with quotient bits
    logic [N-1:0]   dvs_q;
    logic [N-1:0]   rem_q;
    logic           q_neg_q;
    logic           r_neg_q;
    logic [CW-1:0]  cnt_q;
    logic [N-1:0]   out_q;

    // Operand decode at the request
    div_op_e        op_in;
    logic           in_signed;
    logic           a_neg;
    logic           b_neg;
    logic [N-1:0]   abs_a;
    logic [N-1:0]   abs_b;
    logic           div_zero;
    logic           ovf;
    logic           bypass;
    logic [N-1:0]   bypass_result;
    logic           accept;

    assign op_in     = div_op_e'(op);
    assign in_signed = op_is_signed(op_in);
    assign a_neg     = in_signed & inA[N-1];
    assign b_neg     = in_signed & inB[N-1];
    assign abs_a     = a_neg ? -inA : inA;
    assign abs_b     = b_neg ? -inB : inB;
    assign div_zero  = (inB == '0);
    assign ovf       = in_signed && (inA == {1'b1, {(N-1){1'b0}}}) && (inB == '1);
    assign bypass    = div_zero | ovf;
    assign accept    = start & ~flush & ((state == S_IDLE) | (state == S_DONE));

    always_comb begin
        bypass_result = '0;
        if (div_zero) begin
            bypass_result = op_is_rem(op_in) ? inA : '1;
        end else if (ovf) begin
            bypass_result = op_is_rem(op_in) ? '0 : inA;
        end
    end

    // Restoring step: trial-subtract the divisor from the shifted partial
    // remainder at N+1 bits. The partial remainder is always below twice the
    // divisor, so the top bit of the difference is set exactly when the
    // subtraction borrowed.
    logic [N:0] trial_a;
    logic [N:0] trial_b;
    logic [N:0] diff;
    logic       keep;

    assign trial_a = {rem_q, dvd_q[N-1]};
    assign trial_b = {1'b0, dvs_q};
    assign keep    = ~diff[N];

    alu_div_ctrl_alu #(
        .W      (N + 1)
    ) u_alu (
        .op     (ALU_SUB),
        .a      (trial_a),
        .b      (trial_b),
        .result (diff)
    );

    // Sign fix-up and result select
    logic [N-1:0] q_fix;
    logic [N-1:0] r_fix;
    logic [N-1:0] fix_result;

    assign q_fix      = q_neg_q ? -dvd_q : dvd_q;
    assign r_fix      = r_neg_q ? -rem_q : rem_q;
    assign fix_result = op_is_rem(op_q) ? r_fix : q_fix;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_nxt = bypass ? S_DONE : S_ITER;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_ITER: begin
                if (cnt_q == CW'(N - 1)) begin
                    state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                state_nxt = S_DONE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (flush) begin
            state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            op_q    <= DIV_OP_DIV;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            cnt_q   <= '0;
            out_q   <= '0;
        end else if (accept) begin
            op_q    <= op_in;
            dvd_q   <= abs_a;
            dvs_q   <= abs_b;
            rem_q   <= '0;
            q_neg_q <= a_neg ^ b_neg;
            r_neg_q <= a_neg;
            cnt_q   <= '0;
            if (bypass) begin
                out_q <= bypass_result;
            end
        end else if (!flush && state == S_ITER) begin
            rem_q <= keep ? diff[N-1:0] : trial_a[N-1:0];
            dvd_q <= {dvd_q[N-2:0], keep};
            cnt_q <= cnt_q + 1'b1;
        end else if (!flush && state == S_FIX) begin
            out_q <= fix_result;
        end
    end

    assign busy = (state == S_ITER) || (state == S_FIX);
    assign done = (state == S_DONE);
    assign out  = out_q;

endmodule

// File: tb/tb_alu_div_ctrl.sv
// tb/tb_alu_div_ctrl.sv - scoreboard testbench for alu_div_ctrl
module tb_alu_div_ctrl;
    import alu_div_ctrl_pkg::*;

    localparam int N = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [1:0]   op    = 2'b00;
    logic [N-1:0] inA   = '0;
    logic [N-1:0] inB   = '0;
    logic         busy;
    logic         done;
    logic [N-1:0] out;

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [N-1:0] val;
        int           at;
    } exp_t;

    exp_t exp_q[$];

    alu_div_ctrl #(.N(N)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .op    (op),
        .inA   (inA),
        .inB   (inB),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .out   (out)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    // Called just after a falling edge; the request is sampled at the next rising edge.
    task automatic issue(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] e, input int lat, input bit expect_it);
        exp_t x;
        if (expect_it) begin
            x.val = e;
            x.at  = cyc + lat;
            exp_q.push_back(x);
        end
        op    = o;
        inA   = a;
        inB   = b;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            step(1);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic run(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] e, input int lat);
        issue(o, a, b, e, lat, 1'b1);
        drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cycle=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            begin : monitor
                exp_t x;
                forever begin
                    @(negedge clock);
                    if (done === 1'b1) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_done out=%h cycle=%0d required=no_done", out, cyc);
                        end else begin
                            x = exp_q.pop_front();
                            check("result", out, x.val);
                            check("done_cycle", N'(cyc), N'(x.at));
                        end
                    end
                end
            end
        join_none

        // Reset state
        step(3);
        check("reset_busy", N'(busy), '0);
        check("reset_done", N'(done), '0);
        check("reset_out", out, '0);
        reset = 1'b1;
        step(1);
        check("idle_busy", N'(busy), '0);

        // Directed vectors; consecutive runs start in the DONE cycle (back-to-back).
        run(DIV_OP_DIVU, 32'd100,        32'd7,          32'd14,         34);
        run(DIV_OP_REMU, 32'd100,        32'd7,          32'd2,          34);
        run(DIV_OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34);
        run(DIV_OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34);
        run(DIV_OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1);
        run(DIV_OP_REM,  32'd5,          32'd0,          32'd5,          1);
        run(DIV_OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1);
        run(DIV_OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1);
        run(DIV_OP_DIVU, 32'd7,          32'd0,          32'hFFFF_FFFF,  1);
        run(DIV_OP_REMU, 32'd7,          32'd0,          32'd7,          1);
        run(DIV_OP_REM,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  1);
        run(DIV_OP_DIV,  32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  34);
        run(DIV_OP_REM,  32'd100,        32'hFFFF_FFF9,  32'd2,          34);
        run(DIV_OP_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         34);
        run(DIV_OP_REM,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  34);
        run(DIV_OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  34);
        run(DIV_OP_REMU, 32'hFFFF_FFFF,  32'h10,         32'hF,          34);
        run(DIV_OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          34);
        run(DIV_OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  34);
        run(DIV_OP_DIV,  32'h8000_0000,  32'd1,          32'h8000_0000,  34);
        run(DIV_OP_DIVU, 32'd0,          32'd5,          32'd0,          34);
        step(2);

        // Start while busy is ignored: a single done at t+34 with the first result.
        issue(DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, 34, 1'b1);
        step(4);
        check("busy_iter", N'(busy), 1);
        op    = DIV_OP_DIVU;
        inA   = 32'd1;
        inB   = 32'd1;
        start = 1'b1;
        step(1);
        start = 1'b0;
        drain();
        step(10);

        // Flush mid-ITER: no done, busy low next cycle, out held, restart completes.
        issue(DIV_OP_DIVU, 32'd1000, 32'd3, 32'd0, 0, 1'b0);
        step(9);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        check("flush_busy", N'(busy), 0);
        check("flush_done", N'(done), 0);
        check("flush_out_held", out, 32'd14);
        run(DIV_OP_REMU, 32'd1000, 32'd3, 32'd1, 34);
        step(2);

        // Flush beats a simultaneous start.
        op    = DIV_OP_DIVU;
        inA   = 32'd9;
        inB   = 32'd3;
        start = 1'b1;
        flush = 1'b1;
        step(1);
        start = 1'b0;
        flush = 1'b0;
        check("flush_start_busy", N'(busy), 0);
        step(40);

        // Reset mid-ITER aborts with no done and clears out.
        issue(DIV_OP_DIVU, 32'd100, 32'd7, 32'd0, 0, 1'b0);
        step(19);
        reset = 1'b0;
        step(1);
        check("rst_mid_busy", N'(busy), 0);
        check("rst_mid_done", N'(done), 0);
        check("rst_mid_out", out, '0);
        reset = 1'b1;
        step(40);

        check("scoreboard_empty", N'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_div_ctrl.md
ALU_DIV_CTRL -- requirements
Module: alu_div_ctrl

Interface
REQ-001 The block SHALL have one parameter: N, default 32, datapath width in bits.
REQ-002 The block SHALL have port clock, input, 1, the single clock, with all state updated on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, a synchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, the operation request, sampled only when accepting.
REQ-005 The block SHALL have port op, input, 2, the operation select: DIV, DIVU, REM or REMU.
REQ-006 The block SHALL have port inA, input, N, the dividend.
REQ-007 The block SHALL have port inB, input, N, the divisor.
REQ-008 The block SHALL have port flush, input, 1, a synchronous abort of the operation in flight.
REQ-009 The block SHALL have port busy, output, 1, high while an operation is iterating or fixing up.
REQ-010 The block SHALL have port done, output, 1, a one-cycle pulse marking out as valid.
REQ-011 The block SHALL have port out, output, N, the quotient or remainder, held until the next accepted start.

Function
REQ-012 The state machine SHALL have the states IDLE, ITER, FIX and DONE; busy SHALL equal (state==ITER or state==FIX).
REQ-013 start SHALL be accepted only in IDLE or DONE (back-to-back allowed); start while busy SHALL be ignored and not queued.
REQ-014 On acceptance, the block SHALL latch op and |inA|, |inB| (absolute values only for DIV/REM), record the result sign, clear the iteration counter, and enter ITER.
REQ-015 Result signs SHALL be: quotient negative iff the operand signs differ; remainder takes the dividend's sign.
REQ-016 Divide-by-zero (inB==0) SHALL bypass ITER and go straight to DONE, with quotient all ones and remainder = inA.
REQ-017 Signed overflow (DIV/REM, inA = most-negative, inB = all ones) SHALL go straight to DONE, with quotient = inA and remainder = 0.
REQ-018 In ITER, each cycle SHALL do one restoring step: shift the dividend MSB into the partial remainder, trial-subtract the divisor via the ALU SUB op, and keep the difference only when the (N+1)-bit unsigned compare shows no borrow; the quotient bit SHALL be 1 iff the difference is kept.
REQ-019 ITER SHALL last exactly N cycles, with a counter of clog2(N)+1 bits; after the Nth step, the next state SHALL be FIX.
REQ-020 FIX SHALL negate the quotient/remainder as recorded, select by op, register out, and enter DONE.
REQ-021 Latency SHALL be: start accepted at cycle t gives done high at cycle t+N+2 (t+34 for N=32), or at cycle t+1 for a bypass case.
REQ-022 done SHALL be high only in DONE, for one cycle; DONE SHALL return to IDLE unless a new start is accepted.
REQ-023 flush SHALL force IDLE at the next edge from any state; no done pulse, out unchanged, and flush SHALL override a simultaneous start.
REQ-024 Arithmetic SHALL be modulo 2^N; negation is two's complement, so negating the most-negative value yields itself.

Reset
REQ-025 While reset is low at a clock edge: state=IDLE, busy=0, done=0, out=0, counter=0, internal registers=0.
REQ-026 Reset SHALL take priority over flush and start and SHALL abort any operation in flight, with no done pulse.

Structure
REQ-027 The op encodings (DIV=2'b00, DIVU=2'b01, REM=2'b10, REMU=2'b11) SHALL be defined in the shared constants header alongside the ALU op codes; state encodings SHALL remain local to the block.
REQ-028 The block SHALL instantiate exactly one ALU sub-module, with op fixed to SUB, for the trial subtraction; no other sub-modules are required.

Verification
REQ-029 DIVU with inA=100, inB=7 SHALL give done at t+34 and out=14; REMU with the same operands SHALL give out=2.
REQ-030 REM with inA=-7, inB=2 SHALL give out=0xFFFFFFFF; DIV with the same operands SHALL give out=0xFFFFFFFD.
REQ-031 DIV with inA=5, inB=0 SHALL give done at t+1 and out=0xFFFFFFFF; REM with inA=5, inB=0 SHALL give out=5.
REQ-032 DIV with inA=0x80000000, inB=0xFFFFFFFF SHALL give out=0x80000000 at t+1; REM with the same operands SHALL give out=0.
REQ-033 A start at t+5 during busy SHALL be ignored (one done at t+34); flush at t+10 SHALL give no done, busy=0 at t+11, and a new start at t+11 SHALL complete normally.
REQ-034 Reset low at t+20 mid-ITER SHALL give busy=0, done=0, out=0 on the next cycle, with no done pulse thereafter.
